mesh_credit_router: RTL and testbench



---
 rtl/noc_params.sv | 36 +++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/mesh_credit_router.sv | 193 +++++++++++++++++++
 tb/tb_mesh_credit_router.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_params.sv
// Shared mesh router types: port indices, flit types and flit field offsets.
package noc_params;

    localparam int PORT_NUM = 5;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } port_t;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_type_t;

    typedef struct packed {
        logic [15:0] type_lsb;
        logic [15:0] x_lsb;
        logic [15:0] y_lsb;
    } flit_offsets_t;

    // Flit layout MSB first: {type[1:0], dest_x, dest_y, payload}
    function automatic flit_offsets_t flit_offsets(input int x_w, input int y_w, input int data_w);
        flit_offsets_t o;
        o.y_lsb    = 16'(data_w);
        o.x_lsb    = 16'(data_w + y_w);
        o.type_lsb = 16'(data_w + y_w + x_w);
        return o;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-request round-robin arbiter; the pointer moves past the winner when update_en is high.
module rr_arbiter #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         update_en,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;

    always_comb begin
        int  idx;
        logic found;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (update_en && (|gnt)) begin
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) ptr <= (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
    end

endmodule

// File: rtl/mesh_credit_router.sv
// Five-port XY wormhole mesh router with credit flow control.
// Optional per-output flit counters are built when ROUTER_STATS_EN is defined.
module mesh_credit_router
    import noc_params::*;
#(
    parameter int BUFFER_SIZE = 4,
    parameter int DATA_W      = 32,
    parameter int X_W         = 2,
    parameter int Y_W         = 2,
    parameter int X_CURRENT   = 0,
    parameter int Y_CURRENT   = 0,
    localparam int FLIT_W     = 2 + X_W + Y_W + DATA_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PORT_NUM-1:0]              valid_i,
    input  logic [PORT_NUM-1:0][FLIT_W-1:0]  data_i,
    output logic [PORT_NUM-1:0]              credit_o,
    output logic [PORT_NUM-1:0]              valid_o,
    output logic [PORT_NUM-1:0][FLIT_W-1:0]  data_o,
    input  logic [PORT_NUM-1:0]              credit_i,
    output logic [PORT_NUM-1:0]              error_o,
    output logic [PORT_NUM-1:0][31:0]        stat_flits_o
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
    localparam flit_offsets_t OFS = flit_offsets(X_W, Y_W, DATA_W);
    localparam int TYPE_LSB = int'(OFS.type_lsb);
    localparam int X_LSB    = int'(OFS.x_lsb);
    localparam int Y_LSB    = int'(OFS.y_lsb);
    localparam logic [X_W-1:0]   X_CUR    = X_W'(X_CURRENT);
    localparam logic [Y_W-1:0]   Y_CUR    = Y_W'(Y_CURRENT);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_SIZE);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUFFER_SIZE - 1);

    logic [FLIT_W-1:0] fifo_mem   [PORT_NUM][BUFFER_SIZE];
    logic [PTR_W-1:0]  rd_ptr     [PORT_NUM];
    logic [PTR_W-1:0]  wr_ptr     [PORT_NUM];
    logic [CNT_W-1:0]  fifo_cnt   [PORT_NUM];
    logic [CNT_W-1:0]  credit_cnt [PORT_NUM];
    logic [PORT_NUM-1:0] out_locked;
    port_t             out_owner  [PORT_NUM];

    logic [PORT_NUM-1:0] nonempty, is_head, is_last, in_locked;
    port_t               front_route [PORT_NUM];
    logic [PORT_NUM-1:0][PORT_NUM-1:0] req, gnt;
    port_t               sel [PORT_NUM];
    logic [PORT_NUM-1:0] grant_new, send, pop, discard, wr_en, drop;

    function automatic port_t route_of(input logic [X_W-1:0] dx, input logic [Y_W-1:0] dy);
        if (dx > X_CUR) return EAST;
        if (dx < X_CUR) return WEST;
        if (dy > Y_CUR) return SOUTH;
        if (dy < Y_CUR) return NORTH;
        return LOCAL;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] v);
        return (v == PTR_LAST) ? '0 : v + 1'b1;
    endfunction

    // Front-of-FIFO decode and head requests towards free outputs
    always_comb begin
        logic [1:0] ftype;
        nonempty  = '0;
        is_head   = '0;
        is_last   = '0;
        in_locked = '0;
        req       = '0;
        ftype     = 2'b00;
        for (int p = 0; p < PORT_NUM; p++) begin
            ftype          = fifo_mem[p][rd_ptr[p]][TYPE_LSB +: 2];
            nonempty[p]    = (fifo_cnt[p] != '0);
            is_head[p]     = (ftype == HEAD) || (ftype == HEADTAIL);
            is_last[p]     = ftype[1];
            front_route[p] = route_of(fifo_mem[p][rd_ptr[p]][X_LSB +: X_W],
                                      fifo_mem[p][rd_ptr[p]][Y_LSB +: Y_W]);
        end
        for (int q = 0; q < PORT_NUM; q++) begin
            if (out_locked[q]) in_locked[out_owner[q]] = 1'b1;
        end
        for (int p = 0; p < PORT_NUM; p++) begin
            if (nonempty[p] && is_head[p] && !in_locked[p] && !out_locked[front_route[p]])
                req[front_route[p]][p] = 1'b1;
        end
    end

    for (genvar q = 0; q < PORT_NUM; q++) begin : g_arb
        rr_arbiter #(.N(PORT_NUM)) u_arb (
            .clk       (clk),
            .rst       (rst),
            .req       (req[q]),
            .update_en (!out_locked[q]),
            .gnt       (gnt[q])
        );
    end

    // Switch allocation: owner selection, credit check, pops and input writes
    always_comb begin
        grant_new = '0;
        send      = '0;
        pop       = '0;
        discard   = '0;
        wr_en     = '0;
        drop      = '0;
        for (int q = 0; q < PORT_NUM; q++) begin
            sel[q] = out_owner[q];
            for (int p = 0; p < PORT_NUM; p++) begin
                if (!out_locked[q] && gnt[q][p]) begin
                    sel[q]       = port_t'(3'(p));
                    grant_new[q] = 1'b1;
                end
            end
            send[q] = (out_locked[q] || grant_new[q]) && nonempty[sel[q]] && (credit_cnt[q] != '0);
            if (send[q]) pop[sel[q]] = 1'b1;
        end
        for (int p = 0; p < PORT_NUM; p++) begin
            discard[p] = nonempty[p] && !is_head[p] && !in_locked[p];
            if (discard[p]) pop[p] = 1'b1;
            drop[p]  = valid_i[p] && (fifo_cnt[p] == FULL_CNT) && !pop[p];
            wr_en[p] = valid_i[p] && !drop[p];
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < PORT_NUM; p++) begin
            if (wr_en[p]) fifo_mem[p][wr_ptr[p]] <= data_i[p];
        end
    end

    // Output register stage with locks, credits and error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o    <= '0;
            data_o     <= '0;
            credit_o   <= '0;
            error_o    <= '0;
            out_locked <= '0;
            for (int i = 0; i < PORT_NUM; i++) begin
                rd_ptr[i]     <= '0;
                wr_ptr[i]     <= '0;
                fifo_cnt[i]   <= '0;
                credit_cnt[i] <= FULL_CNT;
                out_owner[i]  <= LOCAL;
            end
        end else begin
            for (int p = 0; p < PORT_NUM; p++) begin
                credit_o[p] <= pop[p];
                if (wr_en[p]) wr_ptr[p] <= ptr_inc(wr_ptr[p]);
                if (pop[p])   rd_ptr[p] <= ptr_inc(rd_ptr[p]);
                if (wr_en[p] && !pop[p])      fifo_cnt[p] <= fifo_cnt[p] + 1'b1;
                else if (!wr_en[p] && pop[p]) fifo_cnt[p] <= fifo_cnt[p] - 1'b1;
                if (drop[p] || discard[p]) error_o[p] <= 1'b1;
            end
            for (int q = 0; q < PORT_NUM; q++) begin
                valid_o[q] <= send[q];
                if (send[q]) data_o[q] <= fifo_mem[sel[q]][rd_ptr[sel[q]]];
                if (send[q] && is_last[sel[q]]) begin
                    out_locked[q] <= 1'b0;
                end else if (grant_new[q]) begin
                    out_locked[q] <= 1'b1;
                    out_owner[q]  <= sel[q];
                end
                if (send[q] && !credit_i[q]) begin
                    credit_cnt[q] <= credit_cnt[q] - 1'b1;
                end else if (credit_i[q] && !send[q]) begin
                    if (credit_cnt[q] == FULL_CNT) error_o[q] <= 1'b1;
                    else                           credit_cnt[q] <= credit_cnt[q] + 1'b1;
                end
            end
        end
    end

`ifdef ROUTER_STATS_EN
    logic [PORT_NUM-1:0][31:0] stat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else begin
            for (int q = 0; q < PORT_NUM; q++) begin
                if (send[q]) stat_q[q] <= stat_q[q] + 32'd1;
            end
        end
    end

    assign stat_flits_o = stat_q;
`else
    assign stat_flits_o = '0;
`endif

endmodule

// File: tb/tb_mesh_credit_router.sv
// Directed bench for mesh_credit_router at node (1,1) with BUFFER_SIZE=4.
module tb_mesh_credit_router;

    localparam int FW  = 38;
    localparam int P_L = 0, P_N = 1, P_S = 2, P_W = 3, P_E = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    valid_i, credit_o, valid_o, credit_i, error_o;
    logic [4:0][FW-1:0] data_i, data_o;
    logic [4:0][31:0]   stat_flits_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mesh_credit_router #(
        .BUFFER_SIZE(4), .DATA_W(32), .X_W(2), .Y_W(2), .X_CURRENT(1), .Y_CURRENT(1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .data_i       (data_i),
        .credit_o     (credit_o),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .credit_i     (credit_i),
        .error_o      (error_o),
        .stat_flits_o (stat_flits_o)
    );

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [1:0] dx,
                                         input logic [1:0] dy, input logic [31:0] pl);
        return {t, dx, dy, pl};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid_i = '0; credit_i = '0; data_i = '0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (valid_o !== 5'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 00000", valid_o); end
        n_checks++; if (data_o !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", data_o); end
        n_checks++; if (credit_o !== 5'b0) begin n_fail++; $display("FAIL reset_credit: got %b expected 00000", credit_o); end
        n_checks++; if (error_o !== 5'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 00000", error_o); end
        n_checks++; if (stat_flits_o !== '0) begin n_fail++; $display("FAIL reset_stat: got %h expected 0", stat_flits_o); end
    endtask

    task automatic test_local_loopback();
        logic [FW-1:0] f;
        do_reset();
        f = mk(2'd3, 2'd1, 2'd1, 32'hA5A5_0001);
        valid_i[P_L] = 1'b1; data_i[P_L] = f;
        step();
        valid_i = '0;
        n_checks++; if (valid_o !== 5'b0) begin n_fail++; $display("FAIL loop_early: got %b expected 00000", valid_o); end
        step();
        n_checks++; if (valid_o !== 5'b00001) begin n_fail++; $display("FAIL loop_valid: got %b expected 00001", valid_o); end
        n_checks++; if (data_o[P_L] !== f) begin n_fail++; $display("FAIL loop_data: got %h expected %h", data_o[P_L], f); end
        n_checks++; if (credit_o !== 5'b00001) begin n_fail++; $display("FAIL loop_credit: got %b expected 00001", credit_o); end
        step();
        n_checks++; if (valid_o !== 5'b0 || credit_o !== 5'b0) begin n_fail++; $display("FAIL loop_after: got valid %b credit %b expected 0", valid_o, credit_o); end
    endtask

    task automatic test_packet_east();
        logic [FW-1:0] pkt [4];
        logic [FW-1:0] ht;
        do_reset();
        pkt[0] = mk(2'd0, 2'd3, 2'd1, 32'h100);
        pkt[1] = mk(2'd1, 2'd3, 2'd1, 32'h101);
        pkt[2] = mk(2'd1, 2'd3, 2'd1, 32'h102);
        pkt[3] = mk(2'd2, 2'd3, 2'd1, 32'h103);
        for (int c = 0; c < 6; c++) begin
            valid_i[P_W] = (c < 4);
            data_i[P_W]  = (c < 4) ? pkt[c] : '0;
            step();
            if (c == 0 || c == 5) begin
                n_checks++; if (valid_o !== 5'b0) begin n_fail++; $display("FAIL pkt_idle c%0d: got %b expected 00000", c, valid_o); end
            end else begin
                n_checks++; if (valid_o !== 5'b10000 || data_o[P_E] !== pkt[c-1]) begin
                    n_fail++; $display("FAIL pkt_flit%0d: got valid %b data %h expected 10000 %h", c-1, valid_o, data_o[P_E], pkt[c-1]);
                end
                n_checks++; if (credit_o !== 5'b01000) begin n_fail++; $display("FAIL pkt_credit%0d: got %b expected 01000", c-1, credit_o); end
            end
        end
        ht = mk(2'd3, 2'd3, 2'd0, 32'h1FF);
        credit_i[P_E] = 1'b1; valid_i[P_L] = 1'b1; data_i[P_L] = ht;
        step();
        credit_i = '0; valid_i = '0;
        step();
        n_checks++; if (valid_o !== 5'b10000 || data_o[P_E] !== ht) begin
            n_fail++; $display("FAIL pkt_unlock: got valid %b data %h expected 10000 %h", valid_o, data_o[P_E], ht);
        end
        n_checks++; if (credit_o !== 5'b00001) begin n_fail++; $display("FAIL pkt_unlock_credit: got %b expected 00001", credit_o); end
        n_checks++; if (error_o !== 5'b0) begin n_fail++; $display("FAIL pkt_error: got %b expected 00000", error_o); end
    endtask

    task automatic test_arbitration();
        logic [FW-1:0] exp_d [4];
        logic [4:0]    exp_c [4];
        do_reset();
        exp_d[0] = mk(2'd0, 2'd2, 2'd1, 32'h200); exp_c[0] = 5'b00010;
        exp_d[1] = mk(2'd2, 2'd2, 2'd1, 32'h201); exp_c[1] = 5'b00010;
        exp_d[2] = mk(2'd0, 2'd2, 2'd1, 32'h300); exp_c[2] = 5'b00100;
        exp_d[3] = mk(2'd2, 2'd2, 2'd1, 32'h301); exp_c[3] = 5'b00100;
        valid_i[P_N] = 1'b1; data_i[P_N] = exp_d[0];
        valid_i[P_S] = 1'b1; data_i[P_S] = exp_d[2];
        step();
        data_i[P_N] = exp_d[1];
        data_i[P_S] = exp_d[3];
        step();
        valid_i = '0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (valid_o !== 5'b10000 || data_o[P_E] !== exp_d[i] || credit_o !== exp_c[i]) begin
                n_fail++; $display("FAIL arb_seq%0d: got valid %b data %h credit %b expected 10000 %h %b",
                                   i, valid_o, data_o[P_E], credit_o, exp_d[i], exp_c[i]);
            end
            step();
        end
        n_checks++; if (valid_o !== 5'b0) begin n_fail++; $display("FAIL arb_end: got %b expected 00000", valid_o); end
    endtask

    task automatic test_credit_stall();
        logic [FW-1:0] f [6];
        do_reset();
        f[0] = mk(2'd0, 2'd3, 2'd1, 32'h400);
        for (int i = 1; i < 6; i++) f[i] = mk(2'd1, 2'd3, 2'd1, 32'h400 + i);
        for (int c = 0; c < 8; c++) begin
            valid_i[P_L] = (c < 6);
            data_i[P_L]  = (c < 6) ? f[c] : '0;
            step();
            if (c >= 1 && c <= 4) begin
                n_checks++; if (valid_o !== 5'b10000 || data_o[P_E] !== f[c-1]) begin
                    n_fail++; $display("FAIL stall_flow%0d: got valid %b data %h expected 10000 %h", c-1, valid_o, data_o[P_E], f[c-1]);
                end
            end else begin
                n_checks++; if (valid_o !== 5'b0) begin n_fail++; $display("FAIL stall_hold c%0d: got %b expected 00000", c, valid_o); end
            end
        end
        credit_i[P_E] = 1'b1;
        step();
        credit_i = '0;
        n_checks++; if (valid_o !== 5'b0) begin n_fail++; $display("FAIL stall_credit_edge: got %b expected 00000", valid_o); end
        step();
        n_checks++; if (valid_o !== 5'b10000 || data_o[P_E] !== f[4]) begin
            n_fail++; $display("FAIL stall_release: got valid %b data %h expected 10000 %h", valid_o, data_o[P_E], f[4]);
        end
        step();
        n_checks++; if (valid_o !== 5'b0) begin n_fail++; $display("FAIL stall_one_only: got %b expected 00000", valid_o); end
        n_checks++; if (error_o !== 5'b0) begin n_fail++; $display("FAIL stall_error: got %b expected 00000", error_o); end
        do_reset();
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++; if (valid_o !== 5'b0 || credit_o !== 5'b0) begin
                n_fail++; $display("FAIL midrst c%0d: got valid %b credit %b expected 0", c, valid_o, credit_o);
            end
        end
    endtask

    task automatic test_overflow();
        logic [FW-1:0] w [9];
        do_reset();
        w[0] = mk(2'd0, 2'd3, 2'd1, 32'h500);
        for (int i = 1; i < 9; i++) w[i] = mk(2'd1, 2'd3, 2'd1, 32'h500 + i);
        for (int c = 0; c < 9; c++) begin
            valid_i[P_W] = 1'b1; data_i[P_W] = w[c];
            step();
            if (c == 7) begin
                n_checks++; if (error_o !== 5'b0) begin n_fail++; $display("FAIL ovf_before: got %b expected 00000", error_o); end
            end
        end
        valid_i = '0;
        n_checks++; if (error_o !== 5'b01000) begin n_fail++; $display("FAIL ovf_set: got %b expected 01000", error_o); end
        credit_i[P_E] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (c == 0) begin
                n_checks++; if (valid_o !== 5'b0) begin n_fail++; $display("FAIL ovf_drain0: got %b expected 00000", valid_o); end
            end else begin
                n_checks++; if (valid_o !== 5'b10000 || data_o[P_E] !== w[c+3]) begin
                    n_fail++; $display("FAIL ovf_drain%0d: got valid %b data %h expected 10000 %h", c, valid_o, data_o[P_E], w[c+3]);
                end
            end
        end
        credit_i = '0;
        step(); step();
        n_checks++; if (valid_o !== 5'b0) begin n_fail++; $display("FAIL ovf_dropped: got %b expected 00000", valid_o); end
        n_checks++; if (error_o !== 5'b01000) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 01000", error_o); end
        do_reset();
        n_checks++; if (error_o !== 5'b0) begin n_fail++; $display("FAIL ovf_rst_clear: got %b expected 00000", error_o); end
    endtask

    task automatic test_discard();
        do_reset();
        valid_i[P_L] = 1'b1; data_i[P_L] = mk(2'd1, 2'd0, 2'd0, 32'h77);
        step();
        valid_i = '0;
        n_checks++; if (credit_o !== 5'b0) begin n_fail++; $display("FAIL disc_early: got %b expected 00000", credit_o); end
        step();
        n_checks++; if (credit_o !== 5'b00001 || valid_o !== 5'b0) begin
            n_fail++; $display("FAIL disc_pop: got credit %b valid %b expected 00001 00000", credit_o, valid_o);
        end
        n_checks++; if (error_o !== 5'b00001) begin n_fail++; $display("FAIL disc_error: got %b expected 00001", error_o); end
    endtask

    task automatic test_credit_overflow();
        do_reset();
        credit_i[P_E] = 1'b1;
        step();
        credit_i = '0;
        n_checks++; if (error_o !== 5'b10000) begin n_fail++; $display("FAIL credit_ovf: got %b expected 10000", error_o); end
    endtask

    task automatic test_stats();
        int seen;
        logic [31:0] exp_stat;
`ifdef ROUTER_STATS_EN
        exp_stat = 32'd10;
`else
        exp_stat = 32'd0;
`endif
        do_reset();
        seen = 0;
        for (int c = 0; c < 16; c++) begin
            valid_i[P_W] = (c < 10);
            data_i[P_W]  = mk((c == 0) ? 2'd0 : (c == 9) ? 2'd2 : 2'd1, 2'd3, 2'd1, 32'h600 + c);
            step();
            if (valid_o[P_E]) seen++;
            credit_i[P_E] = valid_o[P_E];
        end
        credit_i = '0;
        n_checks++; if (seen !== 10) begin n_fail++; $display("FAIL stat_seen: got %0d expected 10", seen); end
        n_checks++; if (stat_flits_o[P_E] !== exp_stat) begin n_fail++; $display("FAIL stat_east: got %0d expected %0d", stat_flits_o[P_E], exp_stat); end
        n_checks++; if (stat_flits_o[P_W] !== 32'd0) begin n_fail++; $display("FAIL stat_west: got %0d expected 0", stat_flits_o[P_W]); end
        n_checks++; if (error_o !== 5'b0) begin n_fail++; $display("FAIL stat_error: got %b expected 00000", error_o); end
    endtask

    initial begin
        rst = 1'b1; valid_i = '0; credit_i = '0; data_i = '0;
        test_reset();
        test_local_loopback();
        test_packet_east();
        test_arbitration();
        test_credit_stall();
        test_overflow();
        test_discard();
        test_credit_overflow();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
